switch_input_arbiter: RTL
=========================

Name: switch_input_arbiter

Overview:
- Packet-granular round-robin arbiter that merges four 64-bit AXI4-Stream ingress ports (MAC0..MAC3) into the single stream consumed by the switch output-port-lookup stage.
- Stamps the one-hot source-port field in tuser so the lookup stage can learn and forward.
- Has a one-deep registered output stage; never interleaves beats of different packets.

Parameters:
- DATA_W, 64, tdata width per port
- KEEP_W, 8, tkeep width (DATA_W/8)
- USER_W, 128, tuser width
- NPORTS, 4, number of ingress ports (fixed at 4; other values unsupported)

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- s_axis_tdata  in  NPORTS*DATA_W  packed ingress data, port i at [i*DATA_W +: DATA_W]
- s_axis_tkeep  in  NPORTS*KEEP_W  packed byte enables
- s_axis_tuser  in  NPORTS*USER_W  packed sideband
- s_axis_tlast  in  NPORTS  end of packet per port
- s_axis_tvalid  in  NPORTS  beat valid per port
- s_axis_tready  out  NPORTS  beat accept per port
- m_axis_tdata  out  DATA_W  merged data
- m_axis_tkeep  out  KEEP_W  merged byte enables
- m_axis_tuser  out  USER_W  merged sideband, src-port stamped
- m_axis_tlast  out  1  merged end of packet
- m_axis_tvalid  out  1  merged beat valid
- m_axis_tready  in  1  downstream accept
- grant  out  NPORTS  one-hot owner of current packet, 0 when idle

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rr_ptr=0, grant=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep/tuser=0, s_axis_tready=0.
- FSM states are IDLE and PKT.
- IDLE: scan s_axis_tvalid starting at rr_ptr, wrapping 3->0.
  - On the first set bit i, register grant=1<<i and go to PKT.
  - No input is accepted in IDLE; s_axis_tready=0.
  - With no valid inputs, stay in IDLE.
- PKT, owner g:
  - accept = !m_axis_tvalid || m_axis_tready (combinational).
  - s_axis_tready[g] = accept; all other ready bits = 0.
  - Beat handshake (s_axis_tvalid[g] && accept) loads the output register next edge: tdata, tkeep, tlast copied; tuser copied except tuser[23:16] = 8'h01 << (2*g).
  - Handshake with tlast=1: go to IDLE, rr_ptr = (g+1) mod 4, grant=0.
- Output register:
  - m_axis_tvalid set on a load.
  - Cleared when m_axis_tvalid && m_axis_tready and no load on the same edge.
  - Simultaneous drain+load keeps tvalid=1 with the new beat, giving full throughput.
  - Held data is stable while tvalid && !tready.
- Latency: ingress beat appears on m_axis one cycle after its handshake.
  - Between packets there is exactly one idle arbitration cycle, so max utilisation is N/(N+1) for N-beat packets.
- Fairness: a port that just finished has lowest priority next round; no starvation with 4 continuously-valid ports.
- Input tvalid dropping mid-packet: the owner keeps its grant and waits; the arbiter never preempts.
- tkeep is passed untouched; no length checking.
- Reset mid-packet: the partial packet is dropped from the arbiter's view, and the output register clears immediately. Upstream must also reset; a resumed tail is treated as a new packet.
- A single-beat packet (tvalid and tlast in the first beat) is legal: IDLE, then PKT for one beat, then IDLE.

Test Plan:
- Port1 alone sends 3 beats (data 0x11,0x22,0x33, tlast on beat 3, tuser=0), m_axis_tready=1.
  - Expect grant=4'b0010 one cycle after tvalid.
  - Output beats 0x11,0x22,0x33 on consecutive cycles with tuser[23:16]=0x04 and tlast only on 0x33.
- All four ports hold 2-beat packets valid from reset release.
  - Expect output packet order 0,1,2,3, then 0 again if re-offered.
  - Expect one bubble cycle between packets.
  - Expect tuser[23:16]=0x01,0x04,0x10,0x40 respectively.
- Port0 streams a 4-beat packet while m_axis_tready toggles 1,0,0,1,1,1.
  - Expect no beat lost or duplicated; m_axis_tdata stable during low-ready cycles.
  - Expect s_axis_tready[0] low exactly when m_axis_tvalid=1 and m_axis_tready=0.
- Port2 is mid-packet while port3 is valid.
  - Expect s_axis_tready[3]=0 until port2's tlast handshake; port3 granted on the next arbitration.
  - Then rr_ptr wraps: a subsequent port0 request beats a waiting port2.
- Assert reset low asynchronously during beat 2 of a 5-beat packet.
  - Expect m_axis_tvalid=0, grant=0 and all s_axis_tready=0 immediately (before the next edge).
  - After release, first grant goes to the lowest-index valid port.
- Single-beat packets back-to-back on port3 only.
  - Expect one output beat every 2 cycles, each with tlast=1 and grant pulsing 4'b1000.

Source files
------------

// File: rtl/switch_input_arbiter.sv
// Packet-granular round-robin merge of four AXI4-Stream ingress ports.
// Stamps the one-hot source port into tuser[23:16]; one registered output stage.
module switch_input_arbiter #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8,
  parameter int USER_W = 128,
  parameter int NPORTS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS*DATA_W-1:0] s_axis_tdata,
  input  logic [NPORTS*KEEP_W-1:0] s_axis_tkeep,
  input  logic [NPORTS*USER_W-1:0] s_axis_tuser,
  input  logic [NPORTS-1:0]        s_axis_tlast,
  input  logic [NPORTS-1:0]        s_axis_tvalid,
  output logic [NPORTS-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic [KEEP_W-1:0]        m_axis_tkeep,
  output logic [USER_W-1:0]        m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [NPORTS-1:0]        grant
);

  typedef enum logic {
    IDLE,
    PKT
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [1:0]        owner_q, owner_d;
  logic [NPORTS-1:0] grant_q, grant_d;

  logic              found;
  logic [1:0]        pick;
  logic [1:0]        scan_idx;

  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep;
  logic [USER_W-1:0] sel_user;
  logic              sel_last;
  logic              sel_valid;
  logic [USER_W-1:0] user_stamped;
  logic [7:0]        stamp;

  logic              accept;
  logic              load;

  logic [DATA_W-1:0] m_data_q;
  logic [KEEP_W-1:0] m_keep_q;
  logic [USER_W-1:0] m_user_q;
  logic              m_last_q;
  logic              m_valid_q;

  // Rotating scan: first valid port at or after rr_ptr wins.
  always_comb begin
    found    = 1'b0;
    pick     = rr_ptr_q;
    scan_idx = rr_ptr_q;
    for (int k = 0; k < NPORTS; k++) begin
      scan_idx = rr_ptr_q + 2'(k);
      if (!found && s_axis_tvalid[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (owner_q == 2'(i)) begin
        sel_data  = s_axis_tdata[i*DATA_W +: DATA_W];
        sel_keep  = s_axis_tkeep[i*KEEP_W +: KEEP_W];
        sel_user  = s_axis_tuser[i*USER_W +: USER_W];
        sel_last  = s_axis_tlast[i];
        sel_valid = s_axis_tvalid[i];
      end
    end
  end

  always_comb begin
    stamp               = 8'h01 << {owner_q, 1'b0};
    user_stamped        = sel_user;
    user_stamped[23:16] = stamp;
  end

  assign accept = !m_valid_q || m_axis_tready;
  assign load   = (state_q == PKT) && sel_valid && accept;

  always_comb begin
    s_axis_tready = '0;
    if (state_q == PKT) begin
      s_axis_tready = grant_q & {NPORTS{accept}};
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = PKT;
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
        end
      end
      PKT: begin
        if (load && sel_last) begin
          state_d  = IDLE;
          rr_ptr_d = owner_q + 2'd1;
          grant_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
    end
  end

  // A load on the same edge as a drain keeps tvalid high for full throughput.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_user_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else if (load) begin
      m_data_q  <= sel_data;
      m_keep_q  <= sel_keep;
      m_user_q  <= user_stamped;
      m_last_q  <= sel_last;
      m_valid_q <= 1'b1;
    end else if (m_valid_q && m_axis_tready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tvalid = m_valid_q;
  assign grant         = grant_q;

endmodule
